// File: rtl/multi_seq.sv
// Sequential shift-add multiplier: one WIDTH+1-bit adder iterated WIDTH times,
// with sign fix-up, full/truncated product and Z/N/C/V flags.
module multi_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P,
  output logic [WIDTH-1:0]     Pcirc,
  output logic                 Z,
  output logic                 N,
  output logic                 C,
  output logic                 V
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] SIGN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [1:0]         state_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [CW-1:0]      cnt_reg;
  logic               neg_reg;
  logic               mode_reg;
  logic [2*WIDTH-1:0] p_reg;
  logic               z_reg, n_reg, c_reg, v_reg;

  logic               accept;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_shift;
  logic [2*WIDTH-1:0] result;
  logic               res_z, res_n, res_c, res_v;

  assign accept = start && (state_reg == IDLE || state_reg == DONE);

  // Magnitudes are WIDTH-bit unsigned, so the most-negative operand maps to 2^(WIDTH-1).
  assign a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;

  assign sum       = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                   + (mplier_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
  assign acc_shift = {sum, acc_reg[WIDTH-1:1]};

  assign result = neg_reg ? -acc_reg : acc_reg;
  assign res_z  = (result[WIDTH-1:0] == '0);
  assign res_n  = result[WIDTH-1];
  assign res_c  = !mode_reg && (|result[2*WIDTH-1:WIDTH]);
  // Signed overflow: upper half plus the truncated sign bit must be a pure sign extension.
  assign res_v  = mode_reg && !((&result[2*WIDTH-1:WIDTH-1]) || !(|result[2*WIDTH-1:WIDTH-1]));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      neg_reg    <= 1'b0;
      mode_reg   <= 1'b0;
      p_reg      <= '0;
      z_reg      <= 1'b1;
      n_reg      <= 1'b0;
      c_reg      <= 1'b0;
      v_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            state_reg  <= RUN;
            mcand_reg  <= a_mag;
            mplier_reg <= b_mag;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            neg_reg    <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
            mode_reg   <= signed_mode;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          acc_reg    <= acc_shift;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(WIDTH - 1)) begin
            state_reg <= SIGN;
          end
        end
        SIGN: begin
          state_reg <= DONE;
          p_reg     <= result;
          z_reg     <= res_z;
          n_reg     <= res_n;
          c_reg     <= res_c;
          v_reg     <= res_v;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy  = (state_reg == RUN) || (state_reg == SIGN);
  assign done  = (state_reg == DONE);
  assign P     = p_reg;
  assign Pcirc = p_reg[WIDTH-1:0];
  assign Z     = z_reg;
  assign N     = n_reg;
  assign C     = c_reg;
  assign V     = v_reg;

endmodule

// File: tb/tb_multi_seq.sv
// Bench for multi_seq: WIDTH=4 and WIDTH=8 instances checked cycle by cycle
// against an integer-arithmetic product model.
module tb_multi_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_s [2];
  logic       sm_s    [2];
  logic [7:0] a_s     [2];
  logic [7:0] b_s     [2];

  logic       busy4, done4, z4, n4, c4, v4;
  logic [7:0] p4;
  logic [3:0] pc4;
  logic       busy8, done8, z8, n8, c8, v8;
  logic [15:0] p8;
  logic [7:0] pc8;

  logic        busy_s [2];
  logic        done_s [2];
  logic [15:0] p_s    [2];
  logic [7:0]  pc_s   [2];
  logic        z_s [2], n_s [2], c_s [2], v_s [2];

  int pass_cnt = 0;
  int total_cnt = 0;

  multi_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start_s[0]), .signed_mode(sm_s[0]),
    .a(a_s[0][3:0]), .b(b_s[0][3:0]), .busy(busy4), .done(done4),
    .P(p4), .Pcirc(pc4), .Z(z4), .N(n4), .C(c4), .V(v4)
  );

  multi_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start_s[1]), .signed_mode(sm_s[1]),
    .a(a_s[1]), .b(b_s[1]), .busy(busy8), .done(done8),
    .P(p8), .Pcirc(pc8), .Z(z8), .N(n8), .C(c8), .V(v8)
  );

  assign busy_s[0] = busy4;  assign busy_s[1] = busy8;
  assign done_s[0] = done4;  assign done_s[1] = done8;
  assign p_s[0] = {8'h00, p4};  assign p_s[1] = p8;
  assign pc_s[0] = {4'h0, pc4}; assign pc_s[1] = pc8;
  assign z_s[0] = z4; assign z_s[1] = z8;
  assign n_s[0] = n4; assign n_s[1] = n8;
  assign c_s[0] = c4; assign c_s[1] = c8;
  assign v_s[0] = v4; assign v_s[1] = v8;

  // Product and flags from plain integer arithmetic on the operand values.
  function automatic void ref_model(input int w, input logic [7:0] av, input logic [7:0] bv,
                                    input logic sm, output logic [15:0] p,
                                    output logic z, output logic n, output logic c, output logic v);
    int ai, bi, prod, lo;
    ai = int'(av);
    bi = int'(bv);
    if (sm && ai >= (1 << (w - 1))) ai = ai - (1 << w);
    if (sm && bi >= (1 << (w - 1))) bi = bi - (1 << w);
    prod = ai * bi;
    p  = 16'(prod) & 16'((1 << (2 * w)) - 1);
    lo = prod & ((1 << w) - 1);
    z  = (lo == 0);
    n  = ((lo >> (w - 1)) & 1) == 1;
    c  = !sm && (prod >= (1 << w));
    v  = sm && ((prod < -(1 << (w - 1))) || (prod > (1 << (w - 1)) - 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation in the current cycle and follows it to its DONE cycle.
  task automatic run_op(input int d, input logic [7:0] av_in, input logic [7:0] bv_in,
                        input logic sm, input bit mid);
    int w;
    logic [7:0]  av, bv, mask;
    logic [15:0] ep;
    logic ez, en, ec, ev;
    w    = (d == 0) ? 4 : 8;
    mask = 8'((1 << w) - 1);
    av   = av_in & mask;
    bv   = bv_in & mask;
    ref_model(w, av, bv, sm, ep, ez, en, ec, ev);
    a_s[d] = av; b_s[d] = bv; sm_s[d] = sm; start_s[d] = 1'b1;
    tick();
    for (int k = 1; k <= w + 2; k++) begin
      total_cnt++;
      if (busy_s[d] !== (k <= w + 1))
        $display("FAIL busy w=%0d cycle=%0d got=%b want=%b", w, k, busy_s[d], (k <= w + 1));
      else pass_cnt++;
      total_cnt++;
      if (done_s[d] !== (k == w + 2))
        $display("FAIL done w=%0d cycle=%0d got=%b want=%b", w, k, done_s[d], (k == w + 2));
      else pass_cnt++;
      // Operand and start activity while busy must not disturb the result.
      a_s[d] = 8'($urandom); b_s[d] = 8'($urandom); sm_s[d] = 1'($urandom);
      start_s[d] = mid && (k == 2);
      if (k < w + 2) tick();
    end
    start_s[d] = 1'b0;
    total_cnt++;
    if (p_s[d] !== ep) $display("FAIL P w=%0d a=%h b=%h sm=%0d got=%h want=%h", w, av, bv, sm, p_s[d], ep);
    else pass_cnt++;
    total_cnt++;
    if (pc_s[d] !== (ep[7:0] & mask)) $display("FAIL Pcirc w=%0d got=%h want=%h", w, pc_s[d], ep[7:0] & mask);
    else pass_cnt++;
    total_cnt++;
    if ({z_s[d], n_s[d], c_s[d], v_s[d]} !== {ez, en, ec, ev})
      $display("FAIL flags w=%0d a=%h b=%h sm=%0d got ZNCV=%b want=%b", w, av, bv, sm,
               {z_s[d], n_s[d], c_s[d], v_s[d]}, {ez, en, ec, ev});
    else pass_cnt++;
    $display("op w=%0d a=%h b=%h sm=%0d P=%h exp=%h ZNCV=%b", w, av, bv, sm, p_s[d], ep,
             {z_s[d], n_s[d], c_s[d], v_s[d]});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      total_cnt++;
      if ({busy_s[d], done_s[d]} !== 2'b00) $display("FAIL reset_ctrl d=%0d got=%b want=00", d, {busy_s[d], done_s[d]});
      else pass_cnt++;
      total_cnt++;
      if (p_s[d] !== 16'h0 || pc_s[d] !== 8'h0) $display("FAIL reset_P d=%0d got=%h want=0", d, p_s[d]);
      else pass_cnt++;
      total_cnt++;
      if ({z_s[d], n_s[d], c_s[d], v_s[d]} !== 4'b1000)
        $display("FAIL reset_flags d=%0d got=%b want=1000", d, {z_s[d], n_s[d], c_s[d], v_s[d]});
      else pass_cnt++;
    end
    $display("reset applied");
    rst = 1'b0;
    tick();
  endtask

  task automatic test_plan_vectors();
    run_op(0, 8'hF, 8'hF, 1'b0, 1'b0);
    total_cnt++;
    if (p4 !== 8'hE1 || pc4 !== 4'h1) $display("FAIL p15x15 got=%h want=e1", p4);
    else pass_cnt++;
    tick();
    run_op(0, 8'hE, 8'h3, 1'b1, 1'b0); tick();
    run_op(0, 8'hD, 8'h5, 1'b1, 1'b0); tick();
    run_op(0, 8'h8, 8'h8, 1'b1, 1'b0); tick();
    run_op(0, 8'h0, 8'h9, 1'b0, 1'b0); tick();
    for (int i = 0; i < 8; i++) begin
      run_op(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
  endtask

  task automatic test_back_to_back();
    run_op(0, 8'h3, 8'h3, 1'b0, 1'b1);
    run_op(0, 8'h2, 8'h5, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset_abort();
    a_s[0] = 8'h3; b_s[0] = 8'h3; sm_s[0] = 1'b0; start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++;
    if ({busy4, done4} !== 2'b00) $display("FAIL abort_ctrl got=%b want=00", {busy4, done4});
    else pass_cnt++;
    total_cnt++;
    if (p4 !== 8'h00 || z4 !== 1'b1) $display("FAIL abort_P got P=%h Z=%b want P=00 Z=1", p4, z4);
    else pass_cnt++;
    for (int k = 0; k < 8; k++) begin
      tick();
      total_cnt++;
      if ({busy4, done4} !== 2'b00) $display("FAIL abort_idle cycle=%0d got=%b want=00", k, {busy4, done4});
      else pass_cnt++;
    end
    $display("reset abort done");
  endtask

  task automatic test_random8();
    logic [7:0] ca [3] = '{8'h80, 8'hFF, 8'h80};
    logic [7:0] cb [3] = '{8'h80, 8'hFF, 8'h01};
    logic       cs [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      run_op(1, ca[i], cb[i], cs[i], 1'b0);
      tick();
    end
    for (int i = 0; i < 30; i++) begin
      run_op(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
  endtask

  task automatic test_rst_vs_start();
    a_s[1] = 8'h55; b_s[1] = 8'h33; sm_s[1] = 1'b0;
    start_s[1] = 1'b1; rst = 1'b1;
    tick();
    start_s[1] = 1'b0; rst = 1'b0;
    total_cnt++;
    if ({busy8, done8} !== 2'b00 || p8 !== 16'h0) $display("FAIL rst_wins got busy/done=%b P=%h want 00/0", {busy8, done8}, p8);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (busy8 !== 1'b0) $display("FAIL rst_wins_next got busy=%b want=0", busy8);
    else pass_cnt++;
    $display("rst versus start done");
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; sm_s[d] = 1'b0; a_s[d] = 8'h0; b_s[d] = 8'h0;
    end
    test_reset();
    test_plan_vectors();
    test_back_to_back();
    test_reset_abort();
    test_random8();
    test_rst_vs_start();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multi_seq.md
# multi_seq

Parametrised sequential shift-add multiplier, the successor to the 4-bit combinational array multiplier in the FPGA controller ALU path. It uses one adder of WIDTH+1 bits, iterated over WIDTH cycles. It returns the full 2·WIDTH-bit product, the truncated WIDTH-bit result, and valid Z/N/C/V flags. It supports unsigned and two's-complement signed modes, and sits behind the ALU operation select with a start/busy/done handshake.

## Interface
- WIDTH, default 4: operand width; legal range WIDTH ≥ 2.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- signed_mode  input  1  0 = unsigned, 1 = two's-complement; captured with the operands.
- a  input  WIDTH  multiplicand; captured on an accepted start.
- b  input  WIDTH  multiplier; captured on an accepted start.
- busy  output  1  high in RUN and SIGN.
- done  output  1  one-cycle pulse in DONE.
- P  output  2·WIDTH  full product (registered).
- Pcirc  output  WIDTH  P[WIDTH-1:0].
- Z, N, C, V  output  1 each  flags (registered with P).

## Operation
- States: IDLE, RUN, SIGN, DONE.
  - IDLE/DONE with start=1 goes to RUN.
  - RUN goes to SIGN after WIDTH iterations.
  - SIGN goes to DONE.
  - DONE with start=0 goes to IDLE.
- Accepted start captures operands and mode:
  - Unsigned mode: operand magnitudes are a and b as-is.
  - Signed mode: magnitudes are |a| and |b|, taken as WIDTH-bit unsigned, so the most-negative value maps to 2^(WIDTH-1).
  - neg = a[W-1] ^ b[W-1] in signed mode, 0 in unsigned mode.
  - Accumulator cleared; iteration counter cleared.
- RUN, each cycle:
  - If the multiplier LSB = 1, add the multiplicand magnitude into the upper half of the accumulator (WIDTH+1-bit add, carry kept).
  - Shift the accumulator and multiplier right by 1.
  - Increment the counter; exit after exactly WIDTH iterations.
- SIGN: the 2·WIDTH-bit result is the two's-complement negation of the magnitude if neg=1, else the magnitude. It is registered into P, and the flags are registered in the same edge.
- Flags, all computed from the final P:
  - Z = (Pcirc == 0).
  - N = Pcirc[W-1].
  - Unsigned mode: C = |P[2W-1:W]; V = 0.
  - Signed mode: C = 0; V = 1 unless P[2W-1:W-1] is all-zeros or all-ones.
- P and the flags hold their values until the next SIGN→DONE update.
- start while busy is ignored, with no queuing. Operand changes while busy have no effect.

## Timing
- Reset (synchronous): state=IDLE, busy=0, done=0, P=0, Z=1, N=0, C=0, V=0.
- Reset mid-operation aborts the operation and applies the reset values at that edge. No done is issued.
- Cycle numbering (start sampled high at the end of cycle 0):
  - busy=1 in cycles 1..WIDTH+1.
  - P, flags and done become valid in cycle WIDTH+2.
  - Latency is WIDTH+2 cycles; WIDTH=4 gives done in cycle 6.
- done is high for exactly one cycle. busy=0 and done=1 are never both deasserted within DONE.
- Back-to-back operation:
  - start=1 during DONE is accepted; the next cycle is RUN.
  - Throughput is one result per WIDTH+2 cycles.
- Simultaneous rst and start: rst wins.

## Test plan
- WIDTH=4, unsigned, a=15, b=15, start for 1 cycle → done in cycle 6; P=0xE1, Pcirc=0x1, Z=0, N=0, C=1, V=0; busy high in cycles 1–5 only.
- WIDTH=4, signed:
  - a=-2 (0xE), b=3 → P=0xFA, Pcirc=0xA, N=1, V=0, C=0.
  - a=-3 (0xD), b=5 → P=0xF1, V=1.
- WIDTH=4, signed, a=-8, b=-8 → P=0x40, Pcirc=0x0, Z=1, V=1.
- Unsigned, a=0, b=9 → P=0, Z=1, C=0.
- Control sequence:
  - Pulse start with a=3, b=3.
  - At cycle 2, pulse start again with a=7, b=7 → ignored; P=9.
  - Assert start during DONE → second product completes exactly 6 cycles later.
- Assert rst in cycle 3 of an operation → cycle 4 is IDLE, P=0, Z=1, no done pulse.
- Repeat with WIDTH=8, using random operands in both modes against a reference model → P, flags and done in cycle 10 all match.
